xm_mem_bus_ctrl: RTL and testbench
==================================

// Module: xm_mem_bus_ctrl
// PURPOSE
// Memory-access sequencer downstream of the XM control plane. Consumes memEn/memRW/byteOp plus the
// datapath address/store data, runs a req/ack transaction on the external memory bus, and returns
// memBusy (stall) and byte-steered load data. One access in flight; ignores memEn until it returns to IDLE.
// PARAMETERS
// WORD     16  data/address width
// TIMEOUT  64  max WAIT cycles without busAck_i before abort (used only with XM_MEM_TIMEOUT_EN)
// PORTS
// clk_i        in   1     clock, rising edge
// arst_i       in   1     asynchronous reset, active-low
// memEn_i      in   1     access request from control plane
// memRW_i      in   1     1 = write (store), 0 = read (load)
// byteOp_i     in   1     1 = byte access, 0 = word access
// addr_i       in   WORD  byte address
// wrData_i     in   WORD  store data (byte stores use [7:0])
// memBusy_o    out  1     stall to control plane
// rdData_o     out  WORD  load data, valid in DONE
// memFault_o   out  1     1-cycle pulse on timeout abort
// busReq_o     out  1     bus request, held until ack
// busWe_o      out  1     bus write enable
// busAddr_o    out  WORD  word-aligned bus address {addr[WORD-1:1],1'b0}
// busBe_o      out  2     byte lane enables [1]=high byte, [0]=low byte
// busWData_o   out  WORD  bus write data
// busAck_i     in   1     bus completion; read data valid with it
// busRData_i   in   WORD  bus read data
// BEHAVIOUR
// - Reset (arst_i=0, async): state=IDLE; busReq_o, busWe_o, memFault_o=0; busAddr_o, busBe_o, busWData_o,
//   rdData_o=0. memBusy_o then follows the IDLE rule. Reset mid-WAIT drops busReq_o immediately; txn lost.
// - FSM states IDLE, WAIT, DONE:
//   IDLE: memBusy_o = memEn_i (combinational, stalls same cycle). memEn_i=1 at edge -> latch addr/data/rw/byteOp, -> WAIT.
//   WAIT: busReq_o=1, memBusy_o=1, bus outputs stable. busAck_i=1 at edge -> capture load data, -> DONE.
//   DONE: busReq_o=0, memBusy_o=0, rdData_o valid; memEn_i ignored (same access seen unstalled) -> IDLE.
// - Latency: ack in first WAIT cycle gives 3 cycles IDLE->WAIT->DONE; each ack-wait cycle adds 1.
// - busAck_i outside WAIT is ignored. busAddr_o bit0 always 0; word access with addr[0]=1 aligns down.
// - busBe_o: word=2'b11; byte addr[0]=0 -> 2'b01, addr[0]=1 -> 2'b10.
// - Byte store: busWData_o = {wrData_i[7:0], wrData_i[7:0]}; word store passes wrData_i.
// - Byte load: lane chosen by latched addr[0], zero-extended into rdData_o[7:0]; word load = busRData_i.
// - rdData_o holds last load value until next read's ack; writes leave it unchanged.
// CONFIGURATION
// XM_MEM_TIMEOUT_EN defined: counter clears on WAIT entry, increments per WAIT cycle.
//   If it reaches TIMEOUT-1 with no ack -> DONE with rdData_o=16'hFFFF, memFault_o=1 for the DONE cycle.
//   Ack on the same edge as timeout wins (normal completion, no fault).
// XM_MEM_TIMEOUT_EN undefined: WAIT is unbounded, no counter, memFault_o tied 0 (port kept).
// STRUCTURE
// - Package xm_mem_pkg: state enum (IDLE/WAIT/DONE), BE_WORD/BE_LO/BE_HI constants, TIMEOUT default.
// - Sub-module xm_byte_lane: combinational byte-enable generation, store replication, load extraction.
// - Top: FSM, request/data latches, optional timeout counter.
// TESTING
// 1 Word read addr=16'h0040, ack after 2 WAIT cycles, rdata=16'hBEEF -> busBe=11, busy 3 cycles, rdData=BEEF in DONE.
// 2 Byte write addr=16'h0041, wrData=16'h12A5 -> busAddr=0040, busBe=10, busWData=A5A5, busWe=1.
// 3 Byte read addr=16'h0043, rdata=16'h7F10 -> rdData=16'h007F; same at addr 0042 -> 16'h0010.
// 4 Ack in first WAIT, memEn held high through DONE -> exactly one busReq pulse, IDLE after, no 2nd access.
// 5 arst_i low in WAIT -> busReq_o=0 without a clock edge; after release, IDLE and memBusy_o=memEn_i.
// 6 XM_MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> memFault_o 1-cycle pulse, rdData=FFFF; ack on timeout edge -> no fault.

Source files
------------

// File: rtl/xm_mem_pkg.sv
// ============================================================================
// Module  : xm_mem_pkg
// Brief   : Shared types and constants for the XM memory bus controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package xm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } xm_state_e;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    localparam int unsigned WORD_DEFAULT    = 16;
    localparam int unsigned TIMEOUT_DEFAULT = 64;

endpackage

`default_nettype wire

// File: rtl/xm_byte_lane.sv
// ============================================================================
// Module  : xm_byte_lane
// Brief   : Byte-enable generation, store replication and load lane extraction.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xm_byte_lane
    import xm_mem_pkg::*;
#(
    parameter int unsigned WORD = WORD_DEFAULT
) (
    input  logic            i_st_byte,
    input  logic            i_st_addr0,
    input  logic [WORD-1:0] i_st_wdata,
    output logic [1:0]      o_be,
    output logic [WORD-1:0] o_wdata,
    input  logic            i_ld_byte,
    input  logic            i_ld_addr0,
    input  logic [WORD-1:0] i_ld_rdata,
    output logic [WORD-1:0] o_rdata
);

    logic [7:0] w_ld_lane;

    always_comb begin
        if (!i_st_byte) begin
            o_be = BE_WORD;
        end else if (i_st_addr0) begin
            o_be = BE_HI;
        end else begin
            o_be = BE_LO;
        end
    end

    // Byte stores drive the same byte on both lanes; the enables pick the target.
    assign o_wdata   = i_st_byte ? {(WORD/8){i_st_wdata[7:0]}} : i_st_wdata;

    assign w_ld_lane = i_ld_addr0 ? i_ld_rdata[15:8] : i_ld_rdata[7:0];
    assign o_rdata   = i_ld_byte ? {{(WORD-8){1'b0}}, w_ld_lane} : i_ld_rdata;

endmodule

`default_nettype wire

// File: rtl/xm_mem_bus_ctrl.sv
// ============================================================================
// Module  : xm_mem_bus_ctrl
// Brief   : Single-outstanding req/ack memory access sequencer with byte steering.
//           Optional WAIT timeout abort enabled by macro XM_MEM_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xm_mem_bus_ctrl
    import xm_mem_pkg::*;
#(
    parameter int unsigned WORD    = WORD_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            memEn_i,
    input  logic            memRW_i,
    input  logic            byteOp_i,
    input  logic [WORD-1:0] addr_i,
    input  logic [WORD-1:0] wrData_i,
    output logic            memBusy_o,
    output logic [WORD-1:0] rdData_o,
    output logic            memFault_o,
    output logic            busReq_o,
    output logic            busWe_o,
    output logic [WORD-1:0] busAddr_o,
    output logic [1:0]      busBe_o,
    output logic [WORD-1:0] busWData_o,
    input  logic            busAck_i,
    input  logic [WORD-1:0] busRData_i
);

    xm_state_e       r_state;
    xm_state_e       w_next;
    logic            w_busy;
    logic            w_accept;
    logic            w_ack;
    logic            w_tmo;

    logic            r_we;
    logic            r_byte;
    logic            r_addr0;
    logic [WORD-1:0] r_addr;
    logic [1:0]      r_be;
    logic [WORD-1:0] r_bwdata;
    logic [WORD-1:0] r_rdata;
    logic            r_fault;

    logic [1:0]      w_st_be;
    logic [WORD-1:0] w_st_wdata;
    logic [WORD-1:0] w_ld_data;

    assign w_accept = (r_state == IDLE) && memEn_i;
    assign w_ack    = (r_state == WAIT) && busAck_i;

    xm_byte_lane #(
        .WORD       (WORD)
    ) u_lane (
        .i_st_byte  (byteOp_i),
        .i_st_addr0 (addr_i[0]),
        .i_st_wdata (wrData_i),
        .o_be       (w_st_be),
        .o_wdata    (w_st_wdata),
        .i_ld_byte  (r_byte),
        .i_ld_addr0 (r_addr0),
        .i_ld_rdata (busRData_i),
        .o_rdata    (w_ld_data)
    );

`ifdef XM_MEM_TIMEOUT_EN
    localparam int unsigned c_CNT_W = $clog2(TIMEOUT) + 1;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // An ack on the expiry edge completes normally.
    assign w_tmo = (r_state == WAIT) && !busAck_i && (r_cnt == c_CNT_W'(TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = memEn_i;
                if (memEn_i) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                w_busy = 1'b1;
                if (busAck_i || w_tmo) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_we     <= 1'b0;
            r_byte   <= 1'b0;
            r_addr0  <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_bwdata <= '0;
        end else if (w_accept) begin
            r_we     <= memRW_i;
            r_byte   <= byteOp_i;
            r_addr0  <= addr_i[0];
            r_addr   <= {addr_i[WORD-1:1], 1'b0};
            r_be     <= w_st_be;
            r_bwdata <= w_st_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_tmo;
            if (w_tmo) begin
                r_rdata <= '1;
            end else if (w_ack && !r_we) begin
                r_rdata <= w_ld_data;
            end
        end
    end

    assign memBusy_o  = w_busy;
    assign rdData_o   = r_rdata;
    assign memFault_o = r_fault;
    assign busReq_o   = (r_state == WAIT);
    assign busWe_o    = r_we;
    assign busAddr_o  = r_addr;
    assign busBe_o    = r_be;
    assign busWData_o = r_bwdata;

endmodule

`default_nettype wire

// File: tb/tb_xm_mem_bus_ctrl.sv
// ============================================================================
// Module  : tb_xm_mem_bus_ctrl
// Brief   : Scoreboard bench for xm_mem_bus_ctrl (timeout cases with XM_MEM_TIMEOUT_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_xm_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        memEn, memRW, byteOp;
    logic [15:0] addr, wrData;
    logic        memBusy, memFault, busReq, busWe, busAck;
    logic [15:0] rdData, busAddr, busWData, busRData;
    logic [1:0]  busBe;

    always #5 clk = ~clk;

    xm_mem_bus_ctrl #(
        .WORD       (16),
        .TIMEOUT    (4)
    ) dut (
        .clk_i      (clk),
        .arst_i     (arst_n),
        .memEn_i    (memEn),
        .memRW_i    (memRW),
        .byteOp_i   (byteOp),
        .addr_i     (addr),
        .wrData_i   (wrData),
        .memBusy_o  (memBusy),
        .rdData_o   (rdData),
        .memFault_o (memFault),
        .busReq_o   (busReq),
        .busWe_o    (busWe),
        .busAddr_o  (busAddr),
        .busBe_o    (busBe),
        .busWData_o (busWData),
        .busAck_i   (busAck),
        .busRData_i (busRData)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  be;
        logic        we;
        logic [15:0] wd;
    } req_t;

    typedef struct {
        logic [15:0] rd;
        logic        flt;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];

    // Bus slave model: acks in WAIT cycle number ack_wait (0 = first), never if negative.
    int          ack_wait  = 0;
    logic [15:0] resp_data = 16'h0000;
    logic        resp_ack  = 1'b0;
    logic        force_ack = 1'b0;
    int          wcnt      = 0;

    assign busAck = resp_ack | force_ack;

    initial busRData = 16'hDEAD;

    always @(posedge clk) begin
        #1;
        if (busReq) begin
            resp_ack = (wcnt == ack_wait);
            busRData = resp_ack ? resp_data : 16'hDEAD;
            wcnt++;
        end else begin
            resp_ack = 1'b0;
            busRData = 16'hDEAD;
            wcnt     = 0;
        end
    end

    // Monitor: request rise pops a bus expectation, request fall pops a completion.
    logic  prev_req  = 1'b0;
    int    req_rises = 0;
    req_t  m_req;
    done_t m_done;

    always @(negedge arst_n) prev_req = 1'b0;

    always @(negedge clk) begin
        if (arst_n) begin
            if (busReq && !prev_req) begin
                req_rises++;
                if (req_q.size() == 0) begin
                    failures++;
                    $display("FAIL req_unexpected: got request at %h with no expectation", busAddr);
                end else begin
                    m_req = req_q.pop_front();
                    chk("busAddr", busAddr, m_req.addr);
                    chk("busBe", busBe, m_req.be);
                    chk("busWe", busWe, m_req.we);
                    chk("busWData", busWData, m_req.wd);
                end
            end
            if (!busReq && prev_req) begin
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected: got completion rdData %h with no expectation", rdData);
                end else begin
                    m_done = done_q.pop_front();
                    chk("rdData", rdData, m_done.rd);
                    chk("memFault", memFault, m_done.flt);
                    chk("busy_done", memBusy, 0);
                end
            end else begin
                chk("fault_quiet", memFault, 0);
            end
            prev_req = busReq;
        end
    end

    task automatic access(input logic rw, input logic bt, input logic [15:0] a,
                          input logic [15:0] wd, input int aw, input logic [15:0] rresp,
                          input logic [15:0] e_addr, input logic [1:0] e_be,
                          input logic [15:0] e_wd, input logic [15:0] e_rd,
                          input logic e_flt, input int e_busy);
        int busy;
        int rises0;
        bit done;
        req_t  r;
        done_t d;
        r.addr = e_addr; r.be = e_be; r.we = rw; r.wd = e_wd;
        d.rd = e_rd; d.flt = e_flt;
        req_q.push_back(r);
        done_q.push_back(d);
        ack_wait  = aw;
        resp_data = rresp;
        rises0    = req_rises;
        @(posedge clk); #1;
        memEn = 1'b1; memRW = rw; byteOp = bt; addr = a; wrData = wd;
        @(negedge clk);
        chk("busy_idle", memBusy, 1);
        busy = 1;
        @(posedge clk); #1;
        addr   = ~a;
        wrData = ~wd;
        done   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!memBusy) begin
                done = 1'b1;
                break;
            end
            busy++;
        end
        if (!done) begin
            failures++;
            $display("FAIL busy_bound: got still busy after 200 cycles expected completion");
        end
        chk("busy_cycles", busy, e_busy);
        @(posedge clk); #1;
        memEn = 1'b0;
        @(negedge clk);
        chk("req_pulses", req_rises - rises0, 1);
        chk("req_idle_after", busReq, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n = 1'b0;
        memEn  = 1'b1; memRW = 1'b0; byteOp = 1'b0;
        addr   = 16'h0000; wrData = 16'h0000;

        #12;
        chk("rst_busReq", busReq, 0);
        chk("rst_busWe", busWe, 0);
        chk("rst_busAddr", busAddr, 16'h0000);
        chk("rst_busBe", busBe, 2'b00);
        chk("rst_busWData", busWData, 16'h0000);
        chk("rst_rdData", rdData, 16'h0000);
        chk("rst_memFault", memFault, 0);
        chk("rst_busy_en1", memBusy, 1);
        memEn = 1'b0;
        #1;
        chk("rst_busy_en0", memBusy, 0);
        @(posedge clk); #1;
        arst_n = 1'b1;

        //     rw  bt    addr      wd        aw  resp      e_addr    e_be   e_wd      e_rd      flt busy
        access(0, 0, 16'h0040, 16'h0000, 1, 16'hBEEF, 16'h0040, 2'b11, 16'h0000, 16'hBEEF, 0, 3);
        access(1, 1, 16'h0041, 16'h12A5, 0, 16'h0000, 16'h0040, 2'b10, 16'hA5A5, 16'hBEEF, 0, 2);
        access(0, 1, 16'h0043, 16'h0000, 2, 16'h7F10, 16'h0042, 2'b10, 16'h0000, 16'h007F, 0, 4);
        access(0, 1, 16'h0042, 16'h0000, 0, 16'h7F10, 16'h0042, 2'b01, 16'h0000, 16'h0010, 0, 2);
        access(1, 0, 16'h0047, 16'h5A3C, 0, 16'h0000, 16'h0046, 2'b11, 16'h5A3C, 16'h0010, 0, 2);
        access(0, 0, 16'h0101, 16'h0000, 3, 16'h1234, 16'h0100, 2'b11, 16'h0000, 16'h1234, 0, 5);
        access(1, 1, 16'h0040, 16'h00C3, 0, 16'h0000, 16'h0040, 2'b01, 16'hC3C3, 16'h1234, 0, 2);

        // Stray ack while idle must not start or complete anything.
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(negedge clk);
        chk("stray_ack_req", busReq, 0);
        chk("stray_ack_busy", memBusy, 0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_req2", busReq, 0);
        chk("stray_ack_rd", rdData, 16'h1234);

        // Asynchronous reset while waiting on the bus.
        begin
            req_t r;
            r.addr = 16'h0080; r.be = 2'b11; r.we = 1'b0; r.wd = 16'h0000;
            req_q.push_back(r);
        end
        ack_wait = -1;
        @(posedge clk); #1;
        memEn = 1'b1; memRW = 1'b0; byteOp = 1'b0; addr = 16'h0080; wrData = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        chk("wait_req", busReq, 1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_req_drop", busReq, 0);
        chk("arst_busy_en1", memBusy, 1);
        memEn = 1'b0;
        #1;
        chk("arst_busy_en0", memBusy, 0);
        chk("arst_rd", rdData, 16'h0000);
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", busReq, 0);
        chk("post_rst_busy", memBusy, 0);

        access(0, 0, 16'h0002, 16'h0000, 0, 16'h0F0F, 16'h0002, 2'b11, 16'h0000, 16'h0F0F, 0, 2);

`ifdef XM_MEM_TIMEOUT_EN
        access(0, 0, 16'h0010, 16'h0000, -1, 16'h0000, 16'h0010, 2'b11, 16'h0000, 16'hFFFF, 1, 5);
        access(0, 0, 16'h0012, 16'h0000, 3, 16'h4242, 16'h0012, 2'b11, 16'h0000, 16'h4242, 0, 5);
`endif

        repeat (3) @(negedge clk);
        chk("req_q_empty", req_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
